// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial unsigned subtractor. A request on start latches a and b. The
// operands are then consumed one bit per clock, LSB first, through a
// full-subtractor cell. Once all WIDTH bits have been consumed, one further
// BUSY cycle transfers the working difference and the final borrow into the
// output registers, and done pulses for one cycle.
//
// done rises WIDTH+1 clock edges after the edge that sampled start. The
// outputs diff, borrow (and ovf) hold their last result until the next
// BUSY-to-DONE transition.
//
// Parameters
//   WIDTH   operand/result width, 2..32
//
// Ports
//   clk     rising-edge clock for all state
//   rst_n   asynchronous active-low reset
//   start   begin a subtraction (accepted in IDLE and DONE, ignored in BUSY)
//   a       minuend, sampled with start
//   b       subtrahend, sampled with start
//   busy    high while the subtraction is in progress
//   done    one-cycle pulse; diff/borrow/ovf updated in this cycle
//   diff    registered a - b modulo 2^WIDTH
//   borrow  registered borrow-out (unsigned a < b)
//   ovf     registered signed overflow of a - b (only with SERIAL_SUB_OVF_EN)
//
// Optional feature
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf port and its logic.

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // The counter must reach WIDTH, so it needs one value beyond WIDTH-1.
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic             bw_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits. The shift registers lose them while the bits are
    // consumed, so they are kept separately for the overflow decision.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
    logic ovf_d;
`endif

    // Full-subtractor cell on the current LSBs.
    logic ai;
    logic bi;
    logic d_bit;
    logic bw_next;

    always_comb begin
        ai      = a_q[0];
        bi      = b_q[0];
        d_bit   = ai ^ bi ^ bw_q;
        bw_next = (~ai & bi) | (~(ai ^ bi) & bw_q);
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: operand signs differ and the result sign differs from a.
    always_comb begin
        ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ work_q[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            bw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        bw_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StBusy;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                StBusy: begin
                    if (cnt_q == CntLast) begin
                        // All bits consumed: publish the result.
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= work_q;
                        borrow_q <= bw_q;
                        state_q  <= StDone;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q    <= ovf_d;
`endif
                    end else begin
                        a_q    <= a_q >> 1;
                        b_q    <= b_q >> 1;
                        // Enter from the MSB end so bit 0 lands at index 0
                        // after WIDTH shifts.
                        work_q <= {d_bit, work_q[WIDTH-1:1]};
                        bw_q   <= bw_next;
                        cnt_q  <= cnt_q + CntW'(1);
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8). A cycle-level arithmetic model
// predicts busy/done/diff/borrow; directed operations also check literal
// results and done latency.

module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes W+1 edges later with the
    // arithmetic difference; requests during the countdown are dropped.
    int           rem = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_borrow = 1'b0;
    logic         p_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      = 0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done   = 1'b1;
                    m_diff   = p_diff;
                    m_borrow = p_borrow;
                    m_ovf    = p_ovf;
                end
            end else if (start) begin
                logic [W:0] ext;
                ext      = {1'b0, a} - {1'b0, b};
                p_diff   = ext[W-1:0];
                p_borrow = ext[W];
                p_ovf    = (a[W-1] ^ b[W-1]) & (a[W-1] ^ p_diff[W-1]);
                rem      = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", busy, rem != 0);
        chk("cyc_done", done, m_done);
        chk("cyc_diff", diff, m_diff);
        chk("cyc_borrow", borrow, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
        chk("cyc_ovf", ovf, m_ovf);
`endif
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) begin
            n_total++;
            n_bad++;
            $display("FAIL wait_done: no done within 40 cycles");
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        issue(av, bv);
        wait_done(n);
        chk({name, "_lat"}, n, W + 1);
        chk({name, "_diff"}, diff, ed);
        chk({name, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"}, ovf, eo);
`else
        if (eo !== 1'b0 && eo !== 1'b1) $display("note: bad ovf literal in %s", name);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        #21 rst_n = 1'b1;
        @(negedge clk);

        op("sub_05_00", 8'h05, 8'h00, 8'h05, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_pulse", done, 0);
        op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        op("sub_ff_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // Second request during BUSY must be ignored.
        issue(8'h10, 8'h01);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ign_lat", n + 3, W + 1);
        chk("ign_diff", diff, 8'h0F);
        chk("ign_borrow", borrow, 0);

        // Back-to-back: start raised in the DONE cycle.
        op("b2b_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_single", done, 0);
        @(negedge clk);

        // Reset 4 cycles into BUSY.
        issue(8'h5A, 8'h3C);
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", seen, 0);
        op("post_5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on the clk rising edge.
REQ-005 Port: a  input  WIDTH  minuend; sampled together with start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled together with start.
REQ-007 Port: busy  output  1  high while a subtraction is in progress.
REQ-008 Port: done  output  1  single-cycle pulse; result outputs valid.
REQ-009 Port: diff  output  WIDTH  registered result, a minus b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  registered borrow-out; 1 when unsigned a < b.
REQ-011 Port (only with SERIAL_SUB_OVF_EN): ovf  output  1  two's-complement signed overflow of a minus b.

Function
REQ-012 States: IDLE, BUSY, DONE; encoding is free; all state, counter, operand, borrow and result registers are clocked by clk.
REQ-013 IDLE or DONE with start=1: latch a and b into shift registers, clear the internal borrow flop, clear the bit counter, go to BUSY.
REQ-014 IDLE with start=0: stay in IDLE; DONE with start=0: go to IDLE.
REQ-015 BUSY: process one bit per clock, LSB first: d = ai XOR bi XOR bw; bw_next = (NOT ai AND bi) OR (NOT(ai XOR bi) AND bw).
REQ-016 BUSY: shift d into a working diff register from the MSB end; increment the counter; after the WIDTH-th bit go to DONE.
REQ-017 On the BUSY-to-DONE edge: load the diff output from the working register and the borrow output from the final borrow (bw_next of bit WIDTH-1).
REQ-018 Latency: done is high for exactly one cycle, beginning WIDTH+1 rising edges after the edge that sampled start.
REQ-019 busy is high exactly in BUSY; done is high exactly in DONE; busy and done are never high together.
REQ-020 start while BUSY: ignored; the operands in flight and the result are unaffected.
REQ-021 start while DONE: accepted as in IDLE (back-to-back operation); the next done follows WIDTH+1 edges later.
REQ-022 diff, borrow (and ovf) hold the previous result throughout BUSY and IDLE; they change only on the BUSY-to-DONE edge.
REQ-023 a and b may change freely after the sampling edge without affecting the result.

Reset
REQ-024 rst_n low: immediately, without waiting for clk, go to IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0, counter and internal registers cleared.
REQ-025 Reset asserted during BUSY aborts the operation; no done pulse is produced for it.
REQ-026 After rst_n deasserts, the first rising edge with start=1 begins a new operation per REQ-013.

Configuration
REQ-027 Macro SERIAL_SUB_OVF_EN: when defined, the ovf port exists and is loaded on the BUSY-to-DONE edge with (a[MSB] XOR b[MSB]) AND (a[MSB] XOR diff[MSB]), using the latched operands.
REQ-028 When SERIAL_SUB_OVF_EN is not defined: no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-029 WIDTH=8; reset, then start with a=0x05, b=0x00 -> done 9 edges later; diff=0x05, borrow=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow=1; a=0xFF, b=0x01 -> diff=0xFE, borrow=0; a=0x00, b=0x00 -> diff=0x00, borrow=0.
REQ-031 Start a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 during BUSY -> single done; diff=0x0F, borrow=0; second request is ignored.
REQ-032 Start raised in the DONE cycle with a=0x80, b=0x01 -> next done 9 edges later; diff=0x7F, borrow=0; ovf=1 when SERIAL_SUB_OVF_EN is defined.
REQ-033 Drop rst_n 4 cycles into BUSY -> busy, done, diff and borrow are 0 immediately with no clock edge; no done pulse; a new start afterwards completes normally.
